ram_port_arbiter: RTL

- Shares one port of a `ram_dp_sr_sw` dual-port RAM between two requesters.
- Typical use: ram_cpri_payload port 0, shared by the ecpri_rx payload writer (requester 0) and the CPU/host access path (requester 1).
- Round-robin arbitration with burst hold and a bounded burst length.
- Drives the RAM's address/cs/we/oe and its bidirectional data pin; returns read data with a valid strobe.

---
 rtl/ram_port_arbiter.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one port of a ram_dp_sr_sw RAM between two requesters.
// Optional statistics counters are enabled with `define RAM_PORT_ARBITER_STATS_EN.
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_0,
    input  logic                  we_0,
    input  logic                  oe_0,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    output logic                  gnt_0,
    output logic [DATA_WIDTH-1:0] rdata_0,
    output logic                  rvalid_0,
    input  logic                  req_1,
    input  logic                  we_1,
    input  logic                  oe_1,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    output logic                  gnt_1,
    output logic [DATA_WIDTH-1:0] rdata_1,
    output logic                  rvalid_1,
    output logic [ADDR_WIDTH-1:0] ram_address,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
`ifdef RAM_PORT_ARBITER_STATS_EN
    ,
    output logic [15:0]           grant_cnt_0,
    output logic [15:0]           grant_cnt_1,
    output logic [15:0]           contention_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_0 = 2'd1,
        ST_OWN_1 = 2'd2
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t                state_r;
    state_t                next_state_s;
    logic                  gnt_0_r;
    logic                  gnt_1_r;
    logic                  last_owner_r;
    logic [7:0]            burst_cnt_r;

    logic                  sel_we_s;
    logic                  sel_oe_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;
    logic                  ram_cs_s;
    logic                  ram_we_s;
    logic                  ram_oe_s;

    logic [DATA_WIDTH-1:0] rdata_0_r;
    logic [DATA_WIDTH-1:0] rdata_1_r;
    logic                  rvalid_0_r;
    logic                  rvalid_1_r;

    // Next-state decision: round robin on contention, forced rotation at burst limit
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_0 && req_1) begin
                    next_state_s = last_owner_r ? ST_OWN_0 : ST_OWN_1;
                end else if (req_0) begin
                    next_state_s = ST_OWN_0;
                end else if (req_1) begin
                    next_state_s = ST_OWN_1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_OWN_0: begin
                if (!req_0) begin
                    next_state_s = req_1 ? ST_OWN_1 : ST_IDLE;
                end else if (req_1 && (burst_cnt_r == BURST_LAST)) begin
                    next_state_s = ST_OWN_1;
                end else begin
                    next_state_s = ST_OWN_0;
                end
            end
            ST_OWN_1: begin
                if (!req_1) begin
                    next_state_s = req_0 ? ST_OWN_0 : ST_IDLE;
                end else if (req_0 && (burst_cnt_r == BURST_LAST)) begin
                    next_state_s = ST_OWN_0;
                end else begin
                    next_state_s = ST_OWN_1;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Ownership FSM with registered grant decode, burst counter and last-owner memory
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            gnt_0_r      <= 1'b0;
            gnt_1_r      <= 1'b0;
            last_owner_r <= 1'b1;
            burst_cnt_r  <= 8'd0;
        end else begin
            state_r <= next_state_s;
            gnt_0_r <= (next_state_s == ST_OWN_0);
            gnt_1_r <= (next_state_s == ST_OWN_1);
            if (next_state_s != state_r) begin
                burst_cnt_r <= 8'd0;
                if (next_state_s == ST_OWN_0) begin
                    last_owner_r <= 1'b0;
                end else if (next_state_s == ST_OWN_1) begin
                    last_owner_r <= 1'b1;
                end else begin
                    // Dropping to IDLE keeps the previous owner as last_owner
                    last_owner_r <= last_owner_r;
                end
            end else if ((state_r != ST_IDLE) && (burst_cnt_r != BURST_LAST)) begin
                burst_cnt_r <= burst_cnt_r + 8'd1;
            end else begin
                burst_cnt_r <= burst_cnt_r;
            end
        end
    end

    // Route the owner's strobes to the RAM; write wins over read
    always_comb begin
        sel_we_s    = 1'b0;
        sel_oe_s    = 1'b0;
        sel_addr_s  = {ADDR_WIDTH{1'b0}};
        sel_wdata_s = {DATA_WIDTH{1'b0}};
        if (gnt_0_r) begin
            sel_we_s    = we_0;
            sel_oe_s    = oe_0;
            sel_addr_s  = addr_0;
            sel_wdata_s = wdata_0;
        end else if (gnt_1_r) begin
            sel_we_s    = we_1;
            sel_oe_s    = oe_1;
            sel_addr_s  = addr_1;
            sel_wdata_s = wdata_1;
        end else begin
            sel_we_s    = 1'b0;
            sel_oe_s    = 1'b0;
        end
        ram_cs_s = sel_we_s | sel_oe_s;
        ram_we_s = sel_we_s;
        ram_oe_s = sel_oe_s & ~sel_we_s;
    end

    assign ram_cs      = ram_cs_s;
    assign ram_we      = ram_we_s;
    assign ram_oe      = ram_oe_s;
    assign ram_address = sel_addr_s;
    assign ram_data    = ram_we_s ? sel_wdata_s : {DATA_WIDTH{1'bz}};

    // Read return, tagged by the requester that owned the port when the read was issued
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_0_r  <= {DATA_WIDTH{1'b0}};
            rdata_1_r  <= {DATA_WIDTH{1'b0}};
            rvalid_0_r <= 1'b0;
            rvalid_1_r <= 1'b0;
        end else begin
            rvalid_0_r <= ram_oe_s & gnt_0_r;
            rvalid_1_r <= ram_oe_s & gnt_1_r;
            if (ram_oe_s && gnt_0_r) begin
                rdata_0_r <= ram_data;
            end else begin
                rdata_0_r <= rdata_0_r;
            end
            if (ram_oe_s && gnt_1_r) begin
                rdata_1_r <= ram_data;
            end else begin
                rdata_1_r <= rdata_1_r;
            end
        end
    end

    assign gnt_0    = gnt_0_r;
    assign gnt_1    = gnt_1_r;
    assign rdata_0  = rdata_0_r;
    assign rdata_1  = rdata_1_r;
    assign rvalid_0 = rvalid_0_r;
    assign rvalid_1 = rvalid_1_r;

`ifdef RAM_PORT_ARBITER_STATS_EN
    logic [15:0] grant_cnt_0_r;
    logic [15:0] grant_cnt_1_r;
    logic [15:0] contention_cnt_r;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic en);
        if (en && (val != 16'hFFFF)) begin
            return val + 16'd1;
        end else begin
            return val;
        end
    endfunction

    // Saturating grant-entry and contention counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt_0_r    <= 16'd0;
            grant_cnt_1_r    <= 16'd0;
            contention_cnt_r <= 16'd0;
        end else begin
            grant_cnt_0_r    <= sat_inc16(grant_cnt_0_r,
                                          (next_state_s == ST_OWN_0) && (state_r != ST_OWN_0));
            grant_cnt_1_r    <= sat_inc16(grant_cnt_1_r,
                                          (next_state_s == ST_OWN_1) && (state_r != ST_OWN_1));
            contention_cnt_r <= sat_inc16(contention_cnt_r,
                                          (gnt_0_r && req_1) || (gnt_1_r && req_0));
        end
    end

    assign grant_cnt_0    = grant_cnt_0_r;
    assign grant_cnt_1    = grant_cnt_1_r;
    assign contention_cnt = contention_cnt_r;
`endif

endmodule
